// File: rtl/core_seq_pkg.sv
// Shared definitions for the multi-cycle RV32I sequencer: state and trap-cause
// encodings, opcode constants and instruction-format tags.
package core_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_ILLEGAL  = 2'b01,
        CAUSE_IMEM_TO  = 2'b10,
        CAUSE_DMEM_TO  = 2'b11
    } cause_t;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
    } inst_fmt_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    // Only the base integer opcodes are executed; FENCE/SYSTEM and the rest trap.
    function automatic logic is_legal_op(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_IMM, OP_OP: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/core_seq_if.sv
// Instruction/data memory request-ready handshake between the sequencer
// (master) and the memory subsystem (slave).
interface core_seq_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (
        output imem_req, dmem_req, dmem_we,
        input  imem_ready, dmem_ready
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we,
        output imem_ready, dmem_ready
    );
endinterface

// File: rtl/core_seq_mem_wait_timer.sv
// Counts consecutive wait cycles of a memory access and flags expiry on the
// cycle the count would reach TIMEOUT without a ready; TIMEOUT=0 never expires.
module core_seq_mem_wait_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic ready,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign expired = 1'b0;
        end else begin : g_timeout
            localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

            logic [CW-1:0] count_reg;

            // Clearing while idle or on ready means every new access starts at zero.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_reg <= '0;
                end else if (!active || ready) begin
                    count_reg <= '0;
                end else begin
                    count_reg <= count_reg + CW'(1);
                end
            end

            assign expired = active && !ready && (count_reg == LAST);
        end
    endgenerate

endmodule

// File: rtl/core_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer: gates datapath write enables
// by phase, runs the memory handshakes, traps on faults and counts retirements.
module core_seq
    import core_seq_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             halt_req,
    input  logic [6:0]       inst_op,
    input  logic             ctrl_reg_wen,
    input  logic             ctrl_mem_w,
    core_seq_if.master       mem,
    output logic             ir_we,
    output logic             pc_we,
    output logic             rf_we,
    output logic             retire,
    output logic             halted,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state
);

    state_t           state_reg, state_next;
    cause_t           cause_reg, cause_next;
    logic [CNT_W-1:0] instret_reg;
    state_t           after_retire;
    logic             wait_active;
    logic             wait_ready;
    logic             wait_expired;

    // halt_req only matters at an instruction boundary.
    assign after_retire = halt_req ? ST_IDLE : ST_FETCH;
    assign wait_active  = (state_reg == ST_FETCH) || (state_reg == ST_MEM);
    assign wait_ready   = (state_reg == ST_FETCH) ? mem.imem_ready : mem.dmem_ready;

    core_seq_mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .active  (wait_active),
        .ready   (wait_ready),
        .expired (wait_expired)
    );

    always_comb begin
        state_next   = state_reg;
        cause_next   = cause_reg;
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        rf_we        = 1'b0;
        retire       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (!halt_req) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                mem.imem_req = 1'b1;
                if (mem.imem_ready) begin
                    ir_we      = 1'b1;
                    state_next = ST_DECODE;
                end else if (wait_expired) begin
                    state_next = ST_TRAP;
                    cause_next = CAUSE_IMEM_TO;
                end
            end
            ST_DECODE: begin
                if (is_legal_op(inst_op)) begin
                    state_next = ST_EXEC;
                end else begin
                    state_next = ST_TRAP;
                    cause_next = CAUSE_ILLEGAL;
                end
            end
            ST_EXEC: begin
                case (inst_op)
                    OP_LOAD, OP_STORE: state_next = ST_MEM;
                    OP_BRANCH: begin
                        pc_we      = 1'b1;
                        retire     = 1'b1;
                        state_next = after_retire;
                    end
                    default: state_next = ST_WB;
                endcase
            end
            ST_MEM: begin
                mem.dmem_req = 1'b1;
                mem.dmem_we  = ctrl_mem_w;
                if (mem.dmem_ready) begin
                    if (ctrl_mem_w) begin
                        pc_we      = 1'b1;
                        retire     = 1'b1;
                        state_next = after_retire;
                    end else begin
                        state_next = ST_WB;
                    end
                end else if (wait_expired) begin
                    state_next = ST_TRAP;
                    cause_next = CAUSE_DMEM_TO;
                end
            end
            ST_WB: begin
                rf_we      = ctrl_reg_wen;
                pc_we      = 1'b1;
                retire     = 1'b1;
                state_next = after_retire;
            end
            ST_TRAP: ;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            cause_reg   <= CAUSE_NONE;
            instret_reg <= '0;
        end else begin
            state_reg <= state_next;
            cause_reg <= cause_next;
            if (retire) instret_reg <= instret_reg + CNT_W'(1);
        end
    end

    assign halted     = (state_reg == ST_IDLE) && halt_req;
    assign trap       = (state_reg == ST_TRAP);
    assign trap_cause = cause_reg;
    assign instret    = instret_reg;
    assign state      = state_reg;

endmodule

// File: tb/tb_core_seq.sv
// Scoreboard bench for core_seq: directed instructions push expected per-instruction
// profiles; a monitor pops one on every retire or trap entry and compares.
module tb_core_seq;
    import core_seq_pkg::*;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             halt_req;
    logic [6:0]       inst_op;
    logic             ctrl_reg_wen;
    logic             ctrl_mem_w;
    logic             ir_we, pc_we, rf_we, retire, halted, trap;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] instret;
    logic [2:0]       state;

    core_seq_if mem_if ();

    core_seq #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .halt_req     (halt_req),
        .inst_op      (inst_op),
        .ctrl_reg_wen (ctrl_reg_wen),
        .ctrl_mem_w   (ctrl_mem_w),
        .mem          (mem_if),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .rf_we        (rf_we),
        .retire       (retire),
        .halted       (halted),
        .trap         (trap),
        .trap_cause   (trap_cause),
        .instret      (instret),
        .state        (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_trap;
        int          lat;
        int          imem_cyc;
        int          dmem_cyc;
        bit          dmem_we;
        int          rf_cnt;
        int          wb_cyc;
        logic [1:0]  cause;
        logic [31:0] instret_before;
    } exp_t;

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   done_cnt  = 0;
    int   imem_wait = 0;
    int   dmem_wait = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input bit t, input int lat, input int ic, input int dc,
                                input bit dwe, input int rc, input int wc,
                                input logic [1:0] cause, input logic [31:0] ib);
        exp_t e;
        e.is_trap = t; e.lat = lat; e.imem_cyc = ic; e.dmem_cyc = dc; e.dmem_we = dwe;
        e.rf_cnt = rc; e.wb_cyc = wc; e.cause = cause; e.instret_before = ib;
        return e;
    endfunction

    // Memory model: ready is raised after the configured number of wait cycles.
    initial begin
        int iw, dw;
        iw = 0; dw = 0;
        mem_if.imem_ready = 1'b0;
        mem_if.dmem_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_if.imem_req) begin
                if (iw >= imem_wait) begin mem_if.imem_ready = 1'b1; iw = 0; end
                else begin mem_if.imem_ready = 1'b0; iw++; end
            end else begin
                mem_if.imem_ready = 1'b0; iw = 0;
            end
            if (mem_if.dmem_req) begin
                if (dw >= dmem_wait) begin mem_if.dmem_ready = 1'b1; dw = 0; end
                else begin mem_if.dmem_ready = 1'b0; dw++; end
            end else begin
                mem_if.dmem_ready = 1'b0; dw = 0;
            end
        end
    end

    // Monitor: profiles each instruction from FETCH entry to retire/trap.
    initial begin
        int cyc, ic, dc, rc, wc, pc, irc;
        bit dwe;
        logic [2:0] prev;
        exp_t e;
        cyc = 0; ic = 0; dc = 0; rc = 0; wc = 0; pc = 0; irc = 0; dwe = 0; prev = 3'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 3'd0;
                continue;
            end
            check("strobe_phase",
                  {rf_we && state != ST_WB, mem_if.dmem_req && state != ST_MEM,
                   mem_if.imem_req && state != ST_FETCH,
                   (state == ST_TRAP) && (pc_we || ir_we || retire)}, 0);
            if (state == ST_FETCH && prev != ST_FETCH) begin
                cyc = 0; ic = 0; dc = 0; rc = 0; wc = 0; pc = 0; irc = 0; dwe = 0;
            end
            cyc++;
            if (mem_if.imem_req) ic++;
            if (mem_if.dmem_req) dc++;
            if (mem_if.dmem_req && mem_if.dmem_we) dwe = 1'b1;
            if (rf_we) rc++;
            if (state == ST_WB) wc++;
            if (pc_we) pc++;
            if (ir_we) irc++;
            if (retire) begin
                if (sb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_retire: got retire, required none (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    check("retire_not_trap", e.is_trap, 0);
                    check("latency", cyc, e.lat);
                    check("imem_req_cycles", ic, e.imem_cyc);
                    check("dmem_req_cycles", dc, e.dmem_cyc);
                    check("dmem_we_seen", dwe, e.dmem_we);
                    check("rf_we_cycles", rc, e.rf_cnt);
                    check("wb_cycles", wc, e.wb_cyc);
                    check("pc_we_cycles", pc, 1);
                    check("ir_we_cycles", irc, 1);
                    check("instret_at_retire", instret, e.instret_before);
                end
                done_cnt++;
            end
            if (state == ST_TRAP && prev != ST_TRAP) begin
                if (sb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_trap: got cause %0d, required no trap (t=%0t)", trap_cause, $time);
                end else begin
                    e = sb.pop_front();
                    check("trap_expected", e.is_trap, 1);
                    check("trap_cause", trap_cause, e.cause);
                    check("trap_flag", trap, 1);
                    check("trap_imem_cycles", ic, e.imem_cyc);
                    check("trap_dmem_cycles", dc, e.dmem_cyc);
                end
                done_cnt++;
            end
            prev = state;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int target, input int budget);
        int k;
        k = 0;
        while (done_cnt < target && k < budget) begin
            step();
            k++;
        end
        check("done_within_budget", done_cnt >= target, 1);
    endtask

    task automatic issue(input logic [6:0] op, input bit rw, input bit mw,
                         input int iw, input int dw, input exp_t e);
        inst_op      = op;
        ctrl_reg_wen = rw;
        ctrl_mem_w   = mw;
        imem_wait    = iw;
        dmem_wait    = dw;
        sb.push_back(e);
        $display("issue op=%07b reg_wen=%0d mem_w=%0d imem_wait=%0d dmem_wait=%0d", op, rw, mw, iw, dw);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_state", state, ST_IDLE);
        check("rst_instret", instret, 0);
        check("rst_trap", trap, 0);
        check("rst_cause", trap_cause, CAUSE_NONE);
        check("rst_strobes", {mem_if.imem_req, mem_if.dmem_req, ir_we, pc_we, rf_we, retire}, 0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        halt_req = 1'b1; inst_op = OP_IMM; ctrl_reg_wen = 1'b0; ctrl_mem_w = 1'b0;
        rst_n = 1'b0;
        step();
        do_reset();
        rst_n = 1'b1;
        step(); step();
        check("halted_idle_state", state, ST_IDLE);
        check("halted_flag", halted, 1);

        // ADDI x1,x0,5 zero-wait
        issue(OP_IMM, 1, 0, 0, 0, mk(0, 4, 1, 0, 0, 1, 1, 2'b00, 0));
        halt_req = 1'b0;
        wait_done(1, 20);
        // LW with 3 wait cycles on dmem
        issue(OP_LOAD, 1, 0, 0, 3, mk(0, 8, 1, 4, 0, 1, 1, 2'b00, 1));
        wait_done(2, 30);
        // BEQ taken, then SW
        issue(OP_BRANCH, 0, 0, 0, 0, mk(0, 3, 1, 0, 0, 0, 0, 2'b00, 2));
        wait_done(3, 20);
        issue(OP_STORE, 0, 1, 0, 0, mk(0, 4, 1, 1, 1, 0, 0, 2'b00, 3));
        wait_done(4, 20);
        check("instret_after_sw", instret, 4);
        // imem ready on the 4th FETCH cycle wins over the timeout
        issue(OP_IMM, 1, 0, 3, 0, mk(0, 7, 4, 0, 0, 1, 1, 2'b00, 4));
        wait_done(5, 30);
        // halt raised mid-load
        issue(OP_LOAD, 1, 0, 0, 2, mk(0, 7, 1, 3, 0, 1, 1, 2'b00, 5));
        k = 0;
        while (state != ST_MEM && k < 20) begin step(); k++; end
        check("reached_mem", state, ST_MEM);
        halt_req = 1'b1;
        wait_done(6, 30);
        check("halt_after_load_state", state, ST_IDLE);
        check("halt_after_load_halted", halted, 1);
        step(); step();
        check("halt_holds_idle", state, ST_IDLE);
        issue(OP_OP, 1, 0, 0, 0, mk(0, 4, 1, 0, 0, 1, 1, 2'b00, 6));
        halt_req = 1'b0;
        step();
        check("resume_fetch", state, ST_FETCH);
        wait_done(7, 20);
        // illegal opcode
        issue(7'h7F, 1, 0, 0, 0, mk(1, 0, 1, 0, 0, 0, 0, CAUSE_ILLEGAL, 0));
        wait_done(8, 20);
        halt_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("trap_absorbing", state, ST_TRAP);
            check("trap_no_fetch", mem_if.imem_req, 0);
            check("trap_cause_held", trap_cause, CAUSE_ILLEGAL);
        end
        check("instret_frozen", instret, 7);
        halt_req = 1'b0;
        do_reset();
        // imem timeout
        issue(OP_IMM, 1, 0, 100, 0, mk(1, 0, 4, 0, 0, 0, 0, CAUSE_IMEM_TO, 0));
        rst_n = 1'b1;
        wait_done(9, 30);
        do_reset();
        // dmem timeout
        issue(OP_LOAD, 1, 0, 0, 100, mk(1, 0, 1, 4, 0, 0, 0, CAUSE_DMEM_TO, 0));
        rst_n = 1'b1;
        wait_done(10, 30);
        step();
        check("trap_flag_dmem", trap, 1);
        check("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/core_seq.md
Name: core_seq

Overview:
- Multi-cycle sequencer for the RV32I core. It steps one instruction at a time through FETCH, DECODE, EXEC, MEM and WB.
- It gates the write enables produced by the combinational control decoder, so that the register file, PC and data memory commit only in the correct phase.
- It runs the request/ready handshakes to instruction and data memory, detects illegal opcodes and memory timeouts, and counts retired instructions.

Parameters:
- TIMEOUT, 64, max cycles to wait for a memory ready; 0 disables the timeout
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- halt_req  in  1  debug halt; honoured at instruction boundaries only
- inst_op  in  7  opcode field of the instruction register (IR[6:0])
- ctrl_reg_wen  in  1  reg_wen from the control decoder
- ctrl_mem_w  in  1  mem_rw from the control decoder (1 = write)
- imem_ready  in  1  instruction memory data valid
- dmem_ready  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data access request
- dmem_we  out  1  data write strobe qualifier
- ir_we  out  1  load instruction register
- pc_we  out  1  commit the next PC (datapath selects it via pc_sel)
- rf_we  out  1  register file write enable
- retire  out  1  one-cycle pulse per completed instruction
- halted  out  1  in IDLE with halt_req asserted
- trap  out  1  sticky fault indication
- trap_cause  out  2  00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout
- instret  out  CNT_W  retired-instruction count
- state  out  3  current state, for debug

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All strobes 0; trap=0, trap_cause=00, instret=0, timeout counter=0.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- IDLE:
  - !halt_req -> FETCH.
  - Otherwise stay; halted=1.
- FETCH:
  - imem_req=1 held every cycle until imem_ready.
  - On imem_ready: ir_we=1 that cycle -> DECODE.
  - Timeout counter counts FETCH cycles without ready. If it reaches TIMEOUT (when TIMEOUT>0) -> TRAP with cause 10.
  - A ready in the same cycle the count hits TIMEOUT wins (no trap).
- DECODE:
  - Exactly 1 cycle.
  - inst_op must be one of LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP. Otherwise -> TRAP with cause 01.
  - Else -> EXEC.
- EXEC:
  - Exactly 1 cycle.
  - LOAD/STORE -> MEM.
  - BRANCH: pc_we=1 and retire=1 this cycle (taken/not-taken is already folded into pc_sel); -> IDLE if halt_req, else FETCH.
  - All others -> WB.
- MEM:
  - dmem_req=1 and dmem_we=ctrl_mem_w, both held until dmem_ready. Timeout rules as in FETCH, with cause 11.
  - On ready with a store: pc_we=1 and retire=1 -> IDLE or FETCH, as for branches.
  - On ready with a load -> WB.
- WB:
  - rf_we=ctrl_reg_wen, pc_we=1, retire=1.
  - -> IDLE if halt_req, else FETCH.
- TRAP:
  - Absorbing; leaves only on reset.
  - trap=1, trap_cause held.
  - No strobes; halt_req is ignored.
- Strobes are Moore/Mealy combinational from state, registered inputs and ready. The timeout counter clears on every entry to FETCH or MEM.
- halt_req is sampled only at retire; a halt mid-instruction never aborts the instruction.
- instret increments by 1 on each retire and wraps modulo 2^CNT_W.
- Latency with zero-wait memory: branch 3 cycles; ALU, LUI, AUIPC, JAL and JALR 4 cycles; store 4 cycles; load 5 cycles.
- rf_we is never asserted outside WB; dmem_req never outside MEM; imem_req never outside FETCH.

Decomposition:
- Shared package/header holds:
  - state encodings;
  - trap cause codes;
  - RV32I opcode constants, alongside the existing instruction-format definitions.
- One natural sub-module: mem_wait_timer, which handles counter clear, count, and expiry against TIMEOUT and is shared by FETCH and MEM.

Test Plan:
- ADDI x1,x0,5 with zero-wait memory -> FETCH, DECODE, EXEC, WB over 4 cycles; rf_we=1 in cycle 4 only; retire pulse; instret=1.
- LW with dmem_ready delayed 3 cycles -> dmem_req held 4 cycles with dmem_we=0; WB next; total 8 cycles; instret increments once.
- BEQ taken, then SW -> branch retires in EXEC with pc_we=1 and rf_we=0; the store pulses dmem_we=1 with no WB state; instret=2.
- Opcode 0x7F in IR -> TRAP after DECODE; trap_cause=01; no further imem_req; state stays 6 until rst_n=0, then returns to IDLE with instret=0.
- TIMEOUT=4 with imem_ready held low -> trap_cause=10 after 4 FETCH cycles. Repeat with ready on the 4th cycle -> no trap.
- halt_req asserted mid-load -> the load completes its WB and retires; then IDLE with halted=1; deasserting halt_req resumes FETCH next cycle.
